// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: branch resolution unit plus word-addressed data memory
//
// Purpose:
//   Sits between the EX/MEM and MEM/WB registers and holds no pipeline register
//   of its own. The branch resolution unit (BRU) is purely combinational and
//   picks the next PC. The data memory has a synchronous write, a combinational
//   read and an asynchronous clear. All other EX/MEM fields pass straight through.
//
// Ports:
//   clk               in   1         system clock, rising edge
//   rst               in   1         asynchronous active-low reset (clears memory)
//   wb_res_mux        in   2         writeback result select (pass-through)
//   is_branch         in   1         instruction is a branch or flag jump
//   sel_jflag_branch  in   1         0 = flag jump (jt/jf), 1 = beq/bne
//   sel_beq_bne       in   1         0 = beq, 1 = bne
//   sel_jt_jf         in   1         0 = jt, 1 = jf
//   mem_write         in   1         data-memory write enable
//   flag_code         in   5         index of the flag tested by jt/jf
//   in_next_pc        in   PC_WIDTH  sequential PC+1
//   branch_addr       in   PC_WIDTH  branch/jump target
//   flags             in   6         {nz, ovf, carry, neg, true, zero}
//   alu_res           in   32        ALU result (pass-through)
//   in_mem_addr       in   32        data-memory address
//   in_mem_data       in   32        store data
//   in_reg_dst        in   5         destination register (pass-through)
//   in_immediate      in   32        immediate (pass-through)
//   out_wb_res_mux    out  2         = wb_res_mux
//   out_branch_taken  out  1         branch/jump taken
//   out_next_pc       out  PC_WIDTH  next PC
//   out_mem_data      out  32        memory read data
//   out_alu_res       out  32        = alu_res
//   out_reg_dst       out  5         = in_reg_dst
//   out_imm           out  32        = in_immediate

module mem_stage #(
  parameter int PC_WIDTH  = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          wb_res_mux,
  input  logic                is_branch,
  input  logic                sel_jflag_branch,
  input  logic                sel_beq_bne,
  input  logic                sel_jt_jf,
  input  logic                mem_write,
  input  logic [4:0]          flag_code,
  input  logic [PC_WIDTH-1:0] in_next_pc,
  input  logic [PC_WIDTH-1:0] branch_addr,
  input  logic [5:0]          flags,
  input  logic [31:0]         alu_res,
  input  logic [31:0]         in_mem_addr,
  input  logic [31:0]         in_mem_data,
  input  logic [4:0]          in_reg_dst,
  input  logic [31:0]         in_immediate,
  output logic [1:0]          out_wb_res_mux,
  output logic                out_branch_taken,
  output logic [PC_WIDTH-1:0] out_next_pc,
  output logic [31:0]         out_mem_data,
  output logic [31:0]         out_alu_res,
  output logic [4:0]          out_reg_dst,
  output logic [31:0]         out_imm
);

  // ---------------------------------------------------------------------------
  // Branch resolution unit
  // ---------------------------------------------------------------------------
  logic [7:0] w_flags_ext;
  logic       w_flag_code_valid;
  logic       w_sel_flag;
  logic       w_jflag_cond;
  logic       w_br_cond;
  logic       w_taken;

  // Pad the flag vector to 8 entries so codes 6 and 7 read a defined 0 and the
  // index never leaves the vector; codes 8..31 are rejected via the upper bits.
  assign w_flags_ext       = {2'b00, flags};
  assign w_flag_code_valid = (flag_code[4:3] == 2'b00);
  assign w_sel_flag        = w_flag_code_valid & w_flags_ext[flag_code[2:0]];

  assign w_jflag_cond = sel_jt_jf   ? ~w_sel_flag : w_sel_flag;
  assign w_br_cond    = sel_beq_bne ? ~flags[0]   : flags[0];
  assign w_taken      = is_branch & (sel_jflag_branch ? w_br_cond : w_jflag_cond);

  assign out_branch_taken = w_taken;
  assign out_next_pc      = w_taken ? branch_addr : in_next_pc;

  // ---------------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------------
  logic [31:0]          r_mem [MEM_DEPTH];
  logic [ADDR_BITS-1:0] w_index;
  logic [31-ADDR_BITS:0] w_unused_addr_hi;

  // Upper address bits are deliberately dropped so addresses wrap.
  assign w_index          = in_mem_addr[ADDR_BITS-1:0];
  assign w_unused_addr_hi = in_mem_addr[31:ADDR_BITS];

  // The asynchronous clear wins over any write pending in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (mem_write) begin
      r_mem[w_index] <= in_mem_data;
    end
  end

  // Combinational read: a same-cycle write shows up only after the edge.
  assign out_mem_data = r_mem[w_index];

  // ---------------------------------------------------------------------------
  // Pass-throughs
  // ---------------------------------------------------------------------------
  assign out_wb_res_mux = wb_res_mux;
  assign out_alu_res    = alu_res;
  assign out_reg_dst    = in_reg_dst;
  assign out_imm        = in_immediate;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage

module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  wb_res_mux;
  logic        is_branch;
  logic        sel_jflag_branch;
  logic        sel_beq_bne;
  logic        sel_jt_jf;
  logic        mem_write;
  logic [4:0]  flag_code;
  logic [31:0] in_next_pc;
  logic [31:0] branch_addr;
  logic [5:0]  flags;
  logic [31:0] alu_res;
  logic [31:0] in_mem_addr;
  logic [31:0] in_mem_data;
  logic [4:0]  in_reg_dst;
  logic [31:0] in_immediate;
  logic [1:0]  out_wb_res_mux;
  logic        out_branch_taken;
  logic [31:0] out_next_pc;
  logic [31:0] out_mem_data;
  logic [31:0] out_alu_res;
  logic [4:0]  out_reg_dst;
  logic [31:0] out_imm;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .wb_res_mux       (wb_res_mux),
    .is_branch        (is_branch),
    .sel_jflag_branch (sel_jflag_branch),
    .sel_beq_bne      (sel_beq_bne),
    .sel_jt_jf        (sel_jt_jf),
    .mem_write        (mem_write),
    .flag_code        (flag_code),
    .in_next_pc       (in_next_pc),
    .branch_addr      (branch_addr),
    .flags            (flags),
    .alu_res          (alu_res),
    .in_mem_addr      (in_mem_addr),
    .in_mem_data      (in_mem_data),
    .in_reg_dst       (in_reg_dst),
    .in_immediate     (in_immediate),
    .out_wb_res_mux   (out_wb_res_mux),
    .out_branch_taken (out_branch_taken),
    .out_next_pc      (out_next_pc),
    .out_mem_data     (out_mem_data),
    .out_alu_res      (out_alu_res),
    .out_reg_dst      (out_reg_dst),
    .out_imm          (out_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic expect_val(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] act);
    sb_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got 0x%08h with no expectation queued", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  endtask

  // Read one word; expectation is queued before the address is driven.
  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    expect_val(name, exp);
    in_mem_addr = addr;
    #1;
    chk(out_mem_data);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    in_mem_addr = addr;
    in_mem_data = data;
    mem_write   = 1'b1;
    @(posedge clk);
    #1;
    mem_write   = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        br;
    logic        sjb;
    logic        sbb;
    logic        sjf;
    logic [4:0]  fc;
    logic [5:0]  fl;
    logic [31:0] npc;
    logic [31:0] baddr;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [1:0]  wb;
    logic        exp_taken;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // name, br, sjb, sbb, sjf, fc, flags, npc, baddr, alu, rd, imm, wb, taken, pc
    vecs.push_back('{"nobranch",   1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  6'b111111, 32'h10, 32'h80, 32'h12345678, 5'd9,  32'hFFFF0000, 2'd2, 1'b0, 32'h10});
    vecs.push_back('{"beq_taken",  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  6'b000011, 32'h14, 32'h90, 32'h0,        5'd1,  32'h0,        2'd0, 1'b1, 32'h90});
    vecs.push_back('{"bne_not",    1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  6'b000011, 32'h14, 32'h90, 32'h1,        5'd2,  32'h1,        2'd1, 1'b0, 32'h14});
    vecs.push_back('{"beq_not",    1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  6'b000010, 32'h20, 32'hA0, 32'h2,        5'd3,  32'h2,        2'd3, 1'b0, 32'h20});
    vecs.push_back('{"bne_taken",  1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  6'b000010, 32'h20, 32'hA0, 32'h3,        5'd4,  32'h3,        2'd0, 1'b1, 32'hA0});
    vecs.push_back('{"jt_f3",      1'b1, 1'b0, 1'b0, 1'b0, 5'd3,  6'b001000, 32'h30, 32'hB0, 32'h4,        5'd5,  32'h4,        2'd1, 1'b1, 32'hB0});
    vecs.push_back('{"jf_f3",      1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  6'b001000, 32'h30, 32'hB0, 32'h5,        5'd6,  32'h5,        2'd2, 1'b0, 32'h30});
    vecs.push_back('{"jf_code7",   1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  6'b111111, 32'h34, 32'hC0, 32'h6,        5'd7,  32'h6,        2'd3, 1'b1, 32'hC0});
    vecs.push_back('{"jt_code6",   1'b1, 1'b0, 1'b0, 1'b0, 5'd6,  6'b111111, 32'h38, 32'hC4, 32'h7,        5'd8,  32'h7,        2'd0, 1'b0, 32'h38});
    vecs.push_back('{"jt_code5",   1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  6'b100000, 32'h3C, 32'hC8, 32'h8,        5'd10, 32'h8,        2'd1, 1'b1, 32'hC8});
    vecs.push_back('{"jt_true",    1'b1, 1'b0, 1'b0, 1'b0, 5'd1,  6'b000010, 32'h40, 32'hD0, 32'h9,        5'd11, 32'h9,        2'd2, 1'b1, 32'hD0});
    vecs.push_back('{"jt_code14",  1'b1, 1'b0, 1'b0, 1'b0, 5'd14, 6'b111111, 32'h44, 32'hD4, 32'hA,        5'd12, 32'hA,        2'd3, 1'b0, 32'h44});
    vecs.push_back('{"jf_code31",  1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 6'b111111, 32'h48, 32'hD8, 32'hB,        5'd13, 32'hB,        2'd0, 1'b1, 32'hD8});
    vecs.push_back('{"nobr_jf",    1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 6'b000000, 32'h4C, 32'hDC, 32'hC,        5'd31, 32'hC,        2'd1, 1'b0, 32'h4C});
    vecs.push_back('{"passthru",   1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  6'b000000, 32'h10, 32'h80, 32'h12345678, 5'd9,  32'hFFFF0000, 2'd2, 1'b0, 32'h10});

    rst              = 1'b0;
    wb_res_mux       = 2'd0;
    is_branch        = 1'b0;
    sel_jflag_branch = 1'b0;
    sel_beq_bne      = 1'b0;
    sel_jt_jf        = 1'b0;
    mem_write        = 1'b1;
    flag_code        = 5'd0;
    in_next_pc       = 32'h10;
    branch_addr      = 32'h80;
    flags            = 6'd0;
    alu_res          = 32'hCAFEF00D;
    in_mem_addr      = 32'd3;
    in_mem_data      = 32'h1;
    in_reg_dst       = 5'd17;
    in_immediate     = 32'h0000ABCD;

    // Reset held across several edges with a write asserted: nothing lands.
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_val("rst_pass_alu", 32'hCAFEF00D);
    expect_val("rst_pass_rd",  32'd17);
    expect_val("rst_pass_imm", 32'h0000ABCD);
    #1;
    chk(out_alu_res);
    chk({27'd0, out_reg_dst});
    chk(out_imm);
    mem_write = 1'b0;
    #1;
    rst = 1'b1;

    @(negedge clk);
    rd("rst_rd_a0",   32'd0,   32'h0);
    rd("rst_rd_a5",   32'd5,   32'h0);
    rd("rst_rd_a255", 32'd255, 32'h0);
    rd("rst_blk_a3",  32'd3,   32'h0);

    // Table-driven BRU and pass-through vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      expect_val({vecs[i].name, "_taken"}, {31'd0, vecs[i].exp_taken});
      expect_val({vecs[i].name, "_pc"},    vecs[i].exp_pc);
      expect_val({vecs[i].name, "_alu"},   vecs[i].alu);
      expect_val({vecs[i].name, "_rd"},    {27'd0, vecs[i].rd});
      expect_val({vecs[i].name, "_imm"},   vecs[i].imm);
      expect_val({vecs[i].name, "_wb"},    {30'd0, vecs[i].wb});
      is_branch        = vecs[i].br;
      sel_jflag_branch = vecs[i].sjb;
      sel_beq_bne      = vecs[i].sbb;
      sel_jt_jf        = vecs[i].sjf;
      flag_code        = vecs[i].fc;
      flags            = vecs[i].fl;
      in_next_pc       = vecs[i].npc;
      branch_addr      = vecs[i].baddr;
      alu_res          = vecs[i].alu;
      in_reg_dst       = vecs[i].rd;
      in_immediate     = vecs[i].imm;
      wb_res_mux       = vecs[i].wb;
      #1;
      chk({31'd0, out_branch_taken});
      chk(out_next_pc);
      chk(out_alu_res);
      chk({27'd0, out_reg_dst});
      chk(out_imm);
      chk({30'd0, out_wb_res_mux});
    end

    // Write, read back, neighbour untouched, wrapped alias.
    wr(32'd3, 32'hDEADBEEF);
    rd("wr_a3",       32'd3,   32'hDEADBEEF);
    rd("wr_a4",       32'd4,   32'h0);
    rd("wrap_a259",   32'd259, 32'hDEADBEEF);
    wr(32'h0000_01FF, 32'h600DF00D);
    rd("wr_a255",     32'd255, 32'h600DF00D);
    rd("wrap_hi",     32'hFFFF_FF03, 32'hDEADBEEF);
    wr(32'd0, 32'h11111111);
    rd("wr_a0",       32'd0,   32'h11111111);

    // Same-cycle write then read: old word before the edge, new after.
    wr(32'd10, 32'hA);
    @(negedge clk);
    in_mem_data = 32'hB;
    mem_write   = 1'b1;
    rd("same_before", 32'd10, 32'hA);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    rd("same_after",  32'd10, 32'hB);

    // Reset asserted mid-cycle with a write pending: write discarded, array cleared.
    @(negedge clk);
    in_mem_addr = 32'd7;
    in_mem_data = 32'h55;
    mem_write   = 1'b1;
    #2;
    rst = 1'b0;
    rd("rst_clr_a7",  32'd7, 32'h0);
    rd("rst_clr_a3",  32'd3, 32'h0);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    #1;
    rst = 1'b1;
    rd("rst_mid_a7",  32'd7,  32'h0);
    rd("rst_mid_a10", 32'd10, 32'h0);

    // Write blocked while reset is held.
    @(negedge clk);
    rst         = 1'b0;
    in_mem_addr = 32'd3;
    in_mem_data = 32'h1;
    mem_write   = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    #1;
    rst = 1'b1;
    rd("rst_blk2_a3", 32'd3, 32'h0);

    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
